// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the 8-bit ALU and its command sequencer.
//   - DATA_W / OP_W     : fixed datapath and opcode widths
//   - OP_*              : ALU opcode encodings (OP_RSVD is never executed)
//   - state_t           : sequencer FSM states
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] OP_NOT  = 3'b000;
  localparam logic [OP_W-1:0] OP_OR   = 3'b001;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b010;
  localparam logic [OP_W-1:0] OP_AND  = 3'b011;
  localparam logic [OP_W-1:0] OP_MUL4 = 3'b100;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b101;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b110;
  localparam logic [OP_W-1:0] OP_RSVD = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu.sv
// alu: purely combinational 8-bit ALU driven by alu_sequencer.
//   a, b    in  8  operands
//   opcode  in  3  operation select (see alu_pkg OP_*)
//   y       out 8  result; ADD/SUB wrap mod 256, MUL4 uses low nibbles,
//                  reserved opcode yields 0
module alu
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   opcode,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    y = '0;
    case (opcode)
      OP_NOT:  y = ~a;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_AND:  y = a & b;
      OP_MUL4: y = {4'h0, a[3:0]} * {4'h0, b[3:0]};
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: command-driven initiator for the combinational ALU.
// Accepts one command per cmd valid/ready handshake, registers the ALU
// inputs, captures the ALU result one cycle later and returns it on the
// rsp valid/ready channel. An 8-bit accumulator can replace operand A.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_opcode, cmd_a, cmd_b   command fields
//   cmd_use_acc                take operand A from acc instead of cmd_a
//   alu_a, alu_b, alu_opcode   registered ALU inputs
//   alu_out                    combinational ALU result
//   rsp_valid/rsp_ready        response handshake
//   rsp_data, rsp_err          captured result, reserved-opcode flag
//   rsp_zero, rsp_neg          result flags
//   acc                        current accumulator
//
// Configuration macro: ALU_SEQ_FLAGS_EN
//   defined   -> rsp_zero/rsp_neg are registered from the captured result
//   undefined -> rsp_zero/rsp_neg are tied to 0
module alu_sequencer
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_opcode,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic              cmd_use_acc,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_opcode,
  input  logic [DATA_W-1:0] alu_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              rsp_zero,
  output logic              rsp_neg,
  output logic [DATA_W-1:0] acc
);

  state_t state, state_next;
  logic   err;                 // in-flight command used the reserved opcode
  logic [DATA_W-1:0] capture;  // value rsp_data takes at the end of EXEC

  assign capture = err ? '0 : alu_out;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      state <= state_next;
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = EXEC;
      end
      EXEC: state_next = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand registers, result capture, accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every datapath register is reset so an aborted command leaves nothing behind.
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= OP_NOT;
      err        <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      acc        <= '0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        alu_a      <= cmd_use_acc ? acc : cmd_a;
        alu_b      <= cmd_b;
        alu_opcode <= cmd_opcode;
        err        <= (cmd_opcode == OP_RSVD);
      end
      if (state == EXEC) begin
        rsp_data <= capture;
        rsp_err  <= err;
        if (!err) acc <= alu_out;
      end
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_zero <= 1'b0;
      rsp_neg  <= 1'b0;
    end else if (state == EXEC) begin
      rsp_zero <= (capture == '0);
      rsp_neg  <= capture[DATA_W-1];
    end
  end
`else
  assign rsp_zero = 1'b0;
  assign rsp_neg  = 1'b0;
`endif

endmodule
